// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw buttons in, move/reveal/flag pulses out.
// master drives the btn_* inputs; slave (the conditioner) drives the pulses.
interface button_conditioner_if;
  logic btn_up;
  logic btn_down;
  logic btn_left;
  logic btn_rigth;
  logic btn_select;
  logic btn_flag;
  logic up;
  logic down;
  logic left;
  logic rigth;
  logic select;
  logic selectFlag;

  modport master (
    output btn_up, btn_down, btn_left,
    output btn_rigth, btn_select, btn_flag,
    input  up, down, left, rigth,
    input  select, selectFlag
  );

  modport slave (
    input  btn_up, btn_down, btn_left,
    input  btn_rigth, btn_select, btn_flag,
    output up, down, left, rigth,
    output select, selectFlag
  );
endinterface

// File: rtl/button_conditioner.sv
// Sync, debounce, edge-detect and auto-repeat six raw buttons.
// Ports: clk, reset (async active-low), bus (slave: btn_* in, pulses out).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);
  localparam int NB = 6;
  localparam int ND = 4;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                      ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  // Raw level of a released button.
  localparam logic IDLE_LVL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DELAY,
    REPEAT
  } rpt_e;

  // Index map: 0 up, 1 down, 2 left, 3 rigth, 4 select, 5 flag.
  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q, s2_q;
  logic [NB-1:0] pressed;
  logic [NB-1:0] stable_q, stable_d;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] press;
  logic [DW-1:0] db_cnt_q [NB];
  logic [DW-1:0] db_cnt_d [NB];

  rpt_e          st_q [ND];
  rpt_e          st_d [ND];
  logic [RW-1:0] rc_q [ND];
  logic [RW-1:0] rc_d [ND];
  logic [ND-1:0] req;

  logic [NB-1:0] out_q, out_d;

  assign raw = {bus.btn_flag, bus.btn_select,
                bus.btn_rigth, bus.btn_left,
                bus.btn_down, bus.btn_up};

  assign pressed = ACTIVE_LOW ? ~s2_q : s2_q;
  assign press   = stable_q & ~prev_q;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (pressed[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ND; i++) begin
      st_d[i] = st_q[i];
      rc_d[i] = rc_q[i];
      req[i]  = 1'b0;
      if (!stable_q[i]) begin
        st_d[i] = IDLE;
        rc_d[i] = '0;
      end else begin
        unique case (st_q[i])
          IDLE: begin
            if (press[i]) begin
              st_d[i] = WAIT_DELAY;
              rc_d[i] = '0;
              req[i]  = 1'b1;
            end
          end
          WAIT_DELAY: begin
            if (rc_q[i] == DLY_LAST) begin
              st_d[i] = REPEAT;
              rc_d[i] = '0;
              req[i]  = 1'b1;
            end else begin
              rc_d[i] = rc_q[i] + 1'b1;
            end
          end
          REPEAT: begin
            if (rc_q[i] == PER_LAST) begin
              rc_d[i] = '0;
              req[i]  = 1'b1;
            end else begin
              rc_d[i] = rc_q[i] + 1'b1;
            end
          end
          default: begin
            st_d[i] = IDLE;
            rc_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Fixed priority among directions; losers are dropped.
  // Coincident select and flag cancel each other.
  always_comb begin
    out_d    = '0;
    out_d[0] = req[0];
    out_d[1] = req[1] & ~req[0];
    out_d[2] = req[2] & ~|req[1:0];
    out_d[3] = req[3] & ~|req[2:0];
    out_d[4] = press[4] & ~press[5];
    out_d[5] = press[5] & ~press[4];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= {NB{IDLE_LVL}};
      s2_q     <= {NB{IDLE_LVL}};
      stable_q <= '0;
      prev_q   <= '0;
      out_q    <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= '0;
      end
      for (int i = 0; i < ND; i++) begin
        st_q[i] <= IDLE;
        rc_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      out_q    <= out_d;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      for (int i = 0; i < ND; i++) begin
        st_q[i] <= st_d[i];
        rc_q[i] <= rc_d[i];
      end
    end
  end

  assign bus.up         = out_q[0];
  assign bus.down       = out_q[1];
  assign bus.left       = out_q[2];
  assign bus.rigth      = out_q[3];
  assign bus.select     = out_q[4];
  assign bus.selectFlag = out_q[5];
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a pulse scoreboard.
// Expected pulses are queued by edge number and checked every cycle.
module tb_button_conditioner;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int LAT = DB + 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   q_edge [$];
  int   q_idx  [$];
  logic [5:0] obs;
  logic [5:0] exp_v;

  button_conditioner_if bus_if ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] outs();
    return {bus_if.selectFlag, bus_if.select,
            bus_if.rigth, bus_if.left,
            bus_if.down, bus_if.up};
  endfunction

  // Every cycle: outputs must equal exactly the pulses due at this edge.
  always @(negedge clk) begin
    exp_v = '0;
    while (q_edge.size() > 0 && q_edge[0] <= cyc) begin
      if (q_edge[0] == cyc) exp_v[q_idx[0]] = 1'b1;
      void'(q_edge.pop_front());
      void'(q_idx.pop_front());
    end
    obs = outs();
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL pulses edge=%0d got=%b exp=%b", cyc, obs, exp_v);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_at(input int e, input int idx);
    q_edge.push_back(e);
    q_idx.push_back(idx);
  endtask

  task automatic check(input string tag,
                       input logic [5:0] got,
                       input logic [5:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, want);
    end
  endtask

  initial begin
    int c;
    int r;
    reset = 1'b0;
    bus_if.btn_up     = 1'b1;
    bus_if.btn_down   = 1'b1;
    bus_if.btn_left   = 1'b1;
    bus_if.btn_rigth  = 1'b1;
    bus_if.btn_select = 1'b1;
    bus_if.btn_flag   = 1'b1;
    #1;
    check("reset_state", outs(), 6'b0);
    step(4);
    check("reset_hold", outs(), 6'b0);
    reset = 1'b1;
    step(5);

    // Single select press, no repeat, nothing on release.
    bus_if.btn_select = 1'b0;
    expect_at(cyc + LAT, 4);
    step(30);
    bus_if.btn_select = 1'b1;
    step(15);

    // Bouncing up with 3-cycle lows never settles.
    for (int k = 0; k < 40; k++) begin
      bus_if.btn_up = ((k % 5) < 3) ? 1'b0 : 1'b1;
      step(1);
    end
    bus_if.btn_up = 1'b1;
    step(15);

    // Held rigth: first pulse, delay, then periodic repeat.
    c = cyc;
    bus_if.btn_rigth = 1'b0;
    expect_at(c + 7, 3);
    expect_at(c + 27, 3);
    expect_at(c + 35, 3);
    expect_at(c + 43, 3);
    expect_at(c + 51, 3);
    expect_at(c + 59, 3);
    step(60);
    bus_if.btn_rigth = 1'b1;
    step(20);

    // Up beats left; select and flag cancel.
    bus_if.btn_up   = 1'b0;
    bus_if.btn_left = 1'b0;
    expect_at(cyc + LAT, 0);
    step(12);
    bus_if.btn_up   = 1'b1;
    bus_if.btn_left = 1'b1;
    step(15);
    bus_if.btn_select = 1'b0;
    bus_if.btn_flag   = 1'b0;
    step(12);
    bus_if.btn_select = 1'b1;
    bus_if.btn_flag   = 1'b1;
    step(15);

    // Reset mid-debounce aborts; held button re-presses after release.
    bus_if.btn_down = 1'b0;
    step(5);
    reset = 1'b0;
    #1;
    check("reset_mid_press", outs(), 6'b0);
    step(3);
    reset = 1'b1;
    r = cyc;
    expect_at(r + LAT, 1);
    step(12);
    bus_if.btn_down = 1'b1;
    step(15);

    // Async reset clears a live pulse between edges.
    bus_if.btn_select = 1'b0;
    step(LAT);
    check("pulse_before_async", outs(), 6'b010000);
    reset = 1'b0;
    #1;
    check("async_clear", outs(), 6'b0);
    step(2);
    reset = 1'b1;
    expect_at(cyc + LAT, 4);
    step(10);
    bus_if.btn_select = 1'b1;
    step(15);

    n_cmp++;
    assert (q_edge.size() == 0) else begin
      n_bad++;
      $error("FAIL queue_drain got=%0d exp=0", q_edge.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: held cycles after the first direction pulse before auto-repeat starts.
- REPEAT_PERIOD, 10000000: cycles between auto-repeat pulses.
- ACTIVE_LOW, 1: when 1, raw buttons read 0 when pressed.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- btn_up, btn_down, btn_left, btn_rigth, input, 1 each: raw asynchronous direction buttons.
- btn_select, btn_flag, input, 1 each: raw asynchronous reveal and flag buttons.
- up, down, left, rigth, output, 1 each: registered single-cycle move pulses to the board.
- select, selectFlag, output, 1 each: registered single-cycle reveal and flag pulses to the board.

Function
REQ-003 Each raw input SHALL pass through a 2-flop synchronizer, then be normalized to pressed=1 according to ACTIVE_LOW.
REQ-004 Each button SHALL hold a debounced state `stable` and a counter wide enough for DEBOUNCE_CYCLES (width = clog2(DEBOUNCE_CYCLES+1)).
- Synchronized sample equals `stable`: counter clears to 0.
- Sample differs: counter increments.
- The counter reaching DEBOUNCE_CYCLES-1 while the sample still differs: `stable` toggles and the counter clears on the same edge.
REQ-005 A glitch shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave `stable` unchanged; any return to the `stable` level restarts the count from 0.
REQ-006 A 0->1 transition of `stable` SHALL produce a press event. A 1->0 transition SHALL produce nothing.
REQ-007 Press latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges, measured from the first edge that samples the new raw level to the edge where the output pulse goes high. Every pulse SHALL be high for exactly one cycle.
REQ-008 Each direction button SHALL run an auto-repeat FSM with states IDLE, WAIT_DELAY and REPEAT:
- IDLE -> WAIT_DELAY on a press event; the event pulses.
- WAIT_DELAY counts REPEAT_DELAY cycles, then enters REPEAT and issues one pulse.
- REPEAT issues one pulse every REPEAT_PERIOD cycles.
- Any state -> IDLE in the cycle after `stable` falls; no pulse in that transition.
REQ-009 select and selectFlag SHALL never auto-repeat: one pulse per debounced press.
REQ-010 At most one direction output SHALL be high per cycle. Priority is up > down > left > rigth. Losing events are discarded, not queued.
REQ-011 If select and selectFlag events occur in the same cycle, neither SHALL pulse.
- select/flag and direction events are independent and may pulse in the same cycle.
REQ-012 Repeat counters SHALL be wide enough for max(REPEAT_DELAY, REPEAT_PERIOD) and SHALL not wrap while a button is held indefinitely. The counter reloads at each pulse.

Reset
REQ-013 While reset=0, the following SHALL be forced immediately, regardless of clk:
- all outputs to 0;
- synchronizers and `stable` to not-pressed;
- all counters to 0;
- all FSMs to IDLE.
REQ-014 A button held through reset release SHALL be treated as a new press: one pulse DEBOUNCE_CYCLES+3 edges after release.
REQ-015 Reset asserted mid-debounce or mid-repeat SHALL abort the event with no pulse emitted, either during reset or in the cycle after release.

Verification
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, ACTIVE_LOW=1.
REQ-016 Press btn_select=0 for 30 cycles -> select=1 for exactly one cycle, 7 edges after first sample. Release -> no pulse.
REQ-017 btn_up bounces 0/1 with 3-cycle low segments for 40 cycles, then stays 1 -> up never pulses.
REQ-018 Hold btn_rigth=0 for 60 cycles -> rigth pulses at edge 7, then at edges 27, 35, 43, 51, 59 (relative). Release -> pulses stop within DEBOUNCE_CYCLES+3 edges.
REQ-019 Press btn_up and btn_left simultaneously -> up pulses once and left never pulses. Press btn_select and btn_flag simultaneously -> neither pulses.
REQ-020 Assert reset=0 at cycle 5 of a btn_down press, release after 3 cycles with btn_down still held -> no pulse during reset; exactly one down pulse 7 edges after reset release.
REQ-021 Check reset asynchrony: drop reset=0 between clock edges while a pulse is high -> the output falls before the next rising edge.
